led_array_driver: RTL and testbench
===================================

LED_ARRAY_DRIVER -- requirements
Module: led_array_driver

Interface
REQ-001 SHALL have parameter N, default 8: matrix dimension (N rows x N columns).
REQ-002 SHALL have parameter BLANK_TICKS, default 1: ena ticks of blanking before each row (>=1).
REQ-003 SHALL have parameter DWELL_TICKS, default 4: ena ticks each row is lit (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ena  input  1  display tick from the display divider; one-cycle pulse, or held high for full rate.
REQ-007 SHALL have port cells  input  N*N  game frame; cell (r,c) at bit r*N+c.
REQ-008 SHALL have port load  input  1  one-cycle pulse (game step) requesting capture of cells.
REQ-009 SHALL have port rows  output  N  row select, one-hot active-high, rows[r] drives row r.
REQ-010 SHALL have port cols  output  N  column drive, active-low: cols[c]=0 lights column c.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at the end of row N-1 dwell.

Function
REQ-012 SHALL hold a shadow frame register, a display frame register, a pending flag, a row index and a tick counter.
REQ-013 On load, SHALL copy cells into shadow on that edge and set pending; a second load before swap overwrites shadow.
REQ-014 Scan FSM SHALL have states BLANK and ACTIVE; all counter/state changes occur only on cycles with ena=1.
REQ-015 In BLANK, rows SHALL be all 0 and cols all 1; after BLANK_TICKS ena ticks, go to ACTIVE, counter cleared.
REQ-016 In ACTIVE, rows SHALL be one-hot at current row r and cols[c] = ~display[r*N+c].
REQ-017 After DWELL_TICKS ena ticks in ACTIVE, SHALL go to BLANK and advance r; r wraps N-1 -> 0.
REQ-018 The wrap from N-1 SHALL be the frame boundary: frame_done=1 for that one cycle; if pending, display <= shadow and pending cleared.
REQ-019 If load coincides with the frame boundary, display SHALL take cells directly and pending SHALL remain 0.
REQ-020 Display SHALL never change except at a frame boundary (no tearing mid-frame).
REQ-021 rows, cols and frame_done SHALL be registered; they reflect a transition on the cycle after the causing ena edge.
REQ-022 With ena=0 all state and outputs SHALL hold; load capture SHALL still occur.
REQ-023 Tick counter width SHALL be $clog2(max(BLANK_TICKS,DWELL_TICKS)+1); row index width $clog2(N).

Reset
REQ-024 On rst: state BLANK, r=0, counter 0, shadow=0, display=0, pending=0, rows=0, cols all 1, frame_done=0.
REQ-025 rst asserted mid-row or mid-frame SHALL abort immediately; first lit row after release is row 0, blank frame until a load swaps in.

Structure
REQ-026 Scan state enum (BLANK, ACTIVE) SHALL live in shared package led_array_pkg, alongside default N.
REQ-027 Single module; no sub-module required, FSM, counters and frame buffers kept in led_array_driver.

Verification (N=8, BLANK_TICKS=1, DWELL_TICKS=2, ena=1 unless stated)
REQ-028 Reset release, no load -> rows cycle 00000001..10000000 each lit 2 cycles after 1 blank cycle; cols=8'hFF throughout; frame_done every 24 cycles.
REQ-029 load with cells=64'h0000_0000_0000_00A5 mid-frame -> no change until boundary; next frame row0 lit with cols=8'h5A, other rows cols=8'hFF.
REQ-030 Two loads in one frame (64'h1, then 64'h2) -> next frame shows only 64'h2 (row0 cols=8'hFD).
REQ-031 load on the frame_done cycle with cells=64'hFF00_0000_0000_0000 -> following frame row7 cols=8'h00; pending reads 0.
REQ-032 ena pulsed every 4th cycle -> timing scales x4 (row lit 8 cycles, blank 4); ena=0 for 20 cycles freezes rows/cols.
REQ-033 rst pulsed while row 5 lit -> next cycle rows=0, cols=8'hFF; display cleared; scan restarts at row 0.

Source files
------------

// File: rtl/led_array_driver_pkg.sv
// Shared definitions for the LED matrix scan driver.
//   scan_state_t : scan FSM states (BLANK between rows, ACTIVE while a row is lit)
//   DEFAULT_N    : default matrix dimension
//   max_int      : elaboration-time helper for sizing the tick counter
package led_array_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    BLANK  = 1'b0,
    ACTIVE = 1'b1
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_array_driver_if.sv
// Bundle between the game/display-divider side and the LED matrix driver.
//   ena        : display tick (pulse or held high)
//   load       : one-cycle request to capture cells
//   cells      : N*N game frame, cell (r,c) at bit r*N+c
//   rows       : one-hot active-high row select
//   cols       : active-low column drive
//   frame_done : one-cycle pulse at the end of the last row's dwell
// master drives the inputs of the driver; slave is the driver itself.
interface led_array_driver_if #(
  parameter int N = led_array_pkg::DEFAULT_N
);
  logic           ena;
  logic           load;
  logic [N*N-1:0] cells;
  logic [N-1:0]   rows;
  logic [N-1:0]   cols;
  logic           frame_done;

  modport master (
    output ena, load, cells,
    input  rows, cols, frame_done
  );

  modport slave (
    input  ena, load, cells,
    output rows, cols, frame_done
  );
endinterface

// File: rtl/led_array_driver.sv
// Multiplexed N x N LED matrix driver with double-buffered frames.
// A load captures cells into a shadow buffer; the shadow is promoted to the
// display buffer only at the frame boundary, so a frame is never torn.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : led_array_driver_if.slave (ena, load, cells in; rows, cols, frame_done out)
//
// state  | meaning
// BLANK  | all rows off, columns dark, for BLANK_TICKS ena ticks
// ACTIVE | row r lit with display columns, for DWELL_TICKS ena ticks
module led_array_driver
  import led_array_pkg::*;
#(
  parameter int N           = DEFAULT_N,
  parameter int BLANK_TICKS = 1,
  parameter int DWELL_TICKS = 4
) (
  input logic           clk,
  input logic           rst,
  led_array_driver_if.slave bus
);

  localparam int CW = $clog2(max_int(BLANK_TICKS, DWELL_TICKS) + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  scan_state_t    state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           boundary;

  logic [N*N-1:0] shadow_q, shadow_d;
  logic [N*N-1:0] display_q, display_d;
  logic           pending_q, pending_d;

  logic [N-1:0]   rows_q, rows_d;
  logic [N-1:0]   cols_q, cols_d;
  logic           frame_done_q;
  logic [N*N-1:0] row_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      row_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      rows_q       <= '0;
      cols_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      frame_done_q <= boundary;
    end
  end

  // Scan sequencing; everything holds on cycles without an ena tick.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (bus.ena) begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (row_q == ROW_LAST) begin
              row_d    = '0;
              boundary = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // Frame buffers. A load landing exactly on the boundary bypasses the
  // shadow so it is shown next frame without leaving a stale pending flag.
  always_comb begin
    shadow_d  = bus.load ? bus.cells : shadow_q;
    display_d = display_q;
    pending_d = pending_q | bus.load;
    if (boundary) begin
      if (bus.load) begin
        display_d = bus.cells;
        pending_d = 1'b0;
      end else if (pending_q) begin
        display_d = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Outputs are computed from next-state values so the registered drive
  // changes on the cycle right after the causing ena edge.
  always_comb begin
    rows_d   = '0;
    cols_d   = '1;
    row_bits = '0;
    if (state_d == ACTIVE) begin
      rows_d   = N'(1) << row_d;
      row_bits = display_d >> (int'(row_d) * N);
      cols_d   = ~row_bits[N-1:0];
    end
  end

  assign bus.rows       = rows_q;
  assign bus.cols       = cols_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_array_driver.sv
// Directed bench for led_array_driver with N=8, BLANK_TICKS=1, DWELL_TICKS=2.
// One ena tick sequence: row r is lit for ticks 3r+1 and 3r+2 of a frame and
// blank at tick 3r+3; a frame is 24 ticks and frame_done follows tick 24.
module tb_led_array_driver;
  import led_array_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  led_array_driver_if #(.N(N)) bus ();

  led_array_driver #(
    .N(N),
    .BLANK_TICKS(1),
    .DWELL_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  int          t;          // ena ticks since reset release
  logic        ticked;     // last edge carried an ena tick
  logic [63:0] disp_exp;   // frame expected on the matrix

  function automatic logic [7:0] exp_rows(input int tt);
    int p;
    if (tt == 0) return 8'h00;
    p = (tt - 1) % 24;
    if (p % 3 == 2) return 8'h00;
    return 8'(1) << (p / 3);
  endfunction

  function automatic logic [7:0] exp_cols(input int tt, input logic [63:0] d);
    int p;
    logic [63:0] s;
    if (tt == 0) return 8'hFF;
    p = (tt - 1) % 24;
    if (p % 3 == 2) return 8'hFF;
    s = d >> ((p / 3) * 8);
    return ~s[7:0];
  endfunction

  task automatic tick_cycle();
    logic e;
    e = bus.ena;
    @(posedge clk);
    #1;
    ticked = e;
    if (e) t++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ena = 1'b1;
    bus.load = 1'b0;
    bus.cells = '0;
    @(posedge clk);
    #1;
    compared++;
    if (bus.rows !== 8'h00) begin
      mismatched++; $display("FAIL reset_rows got %h want 00", bus.rows);
    end
    compared++;
    if (bus.cols !== 8'hFF) begin
      mismatched++; $display("FAIL reset_cols got %h want FF", bus.cols);
    end
    compared++;
    if (bus.frame_done !== 1'b0) begin
      mismatched++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done);
    end
    compared++;
    if (dut.pending_q !== 1'b0) begin
      mismatched++; $display("FAIL reset_pending got %b want 0", dut.pending_q);
    end
    rst = 1'b0;
    t = 0;
    disp_exp = '0;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 48; i++) begin
      tick_cycle();
      compared++;
      if (bus.rows !== exp_rows(t)) begin
        mismatched++; $display("FAIL scan_rows t=%0d got %h want %h", t, bus.rows, exp_rows(t));
      end
      compared++;
      if (bus.cols !== 8'hFF) begin
        mismatched++; $display("FAIL scan_cols t=%0d got %h want FF", t, bus.cols);
      end
      compared++;
      if (bus.frame_done !== (t % 24 == 0)) begin
        mismatched++; $display("FAIL scan_frame_done t=%0d got %b want %b", t, bus.frame_done, (t % 24 == 0));
      end
    end
  endtask

  task automatic test_load_mid_frame();
    while (t < 75) begin
      bus.load  = (t + 1 == 54);
      bus.cells = (t + 1 == 54) ? 64'h0000_0000_0000_00A5 : 64'h0;
      tick_cycle();
      bus.load  = 1'b0;
      bus.cells = 64'h0;
      if (t == 72) disp_exp = 64'h0000_0000_0000_00A5;
      compared++;
      if (bus.rows !== exp_rows(t)) begin
        mismatched++; $display("FAIL mid_rows t=%0d got %h want %h", t, bus.rows, exp_rows(t));
      end
      compared++;
      if (bus.cols !== exp_cols(t, disp_exp)) begin
        mismatched++; $display("FAIL mid_cols t=%0d got %h want %h", t, bus.cols, exp_cols(t, disp_exp));
      end
      if (t == 54) begin
        compared++;
        if (dut.pending_q !== 1'b1) begin
          mismatched++; $display("FAIL mid_pending got %b want 1", dut.pending_q);
        end
      end
      if (t == 73) begin
        compared++;
        if (bus.cols !== 8'h5A) begin
          mismatched++; $display("FAIL mid_row0_cols got %h want 5A", bus.cols);
        end
      end
    end
  endtask

  task automatic test_two_loads();
    while (t < 119) begin
      bus.load  = (t + 1 == 78) || (t + 1 == 85);
      bus.cells = (t + 1 == 78) ? 64'h1 : (t + 1 == 85) ? 64'h2 : 64'h0;
      tick_cycle();
      bus.load  = 1'b0;
      bus.cells = 64'h0;
      if (t == 96) disp_exp = 64'h2;
      compared++;
      if (bus.rows !== exp_rows(t)) begin
        mismatched++; $display("FAIL two_rows t=%0d got %h want %h", t, bus.rows, exp_rows(t));
      end
      compared++;
      if (bus.cols !== exp_cols(t, disp_exp)) begin
        mismatched++; $display("FAIL two_cols t=%0d got %h want %h", t, bus.cols, exp_cols(t, disp_exp));
      end
      if (t == 97) begin
        compared++;
        if (bus.cols !== 8'hFD) begin
          mismatched++; $display("FAIL two_row0_cols got %h want FD", bus.cols);
        end
      end
    end
  endtask

  task automatic test_load_on_boundary();
    while (t < 146) begin
      bus.load  = (t + 1 == 120);
      bus.cells = (t + 1 == 120) ? 64'hFF00_0000_0000_0000 : 64'h0;
      tick_cycle();
      bus.load  = 1'b0;
      bus.cells = 64'h0;
      if (t == 120) disp_exp = 64'hFF00_0000_0000_0000;
      compared++;
      if (bus.rows !== exp_rows(t)) begin
        mismatched++; $display("FAIL bnd_rows t=%0d got %h want %h", t, bus.rows, exp_rows(t));
      end
      compared++;
      if (bus.cols !== exp_cols(t, disp_exp)) begin
        mismatched++; $display("FAIL bnd_cols t=%0d got %h want %h", t, bus.cols, exp_cols(t, disp_exp));
      end
      if (t == 120) begin
        compared++;
        if (dut.pending_q !== 1'b0) begin
          mismatched++; $display("FAIL bnd_pending got %b want 0", dut.pending_q);
        end
      end
      if (t == 142) begin
        compared++;
        if (bus.cols !== 8'h00) begin
          mismatched++; $display("FAIL bnd_row7_cols got %h want 00", bus.cols);
        end
      end
    end
  endtask

  task automatic test_reset_mid_row();
    while (t < 160) tick_cycle();
    compared++;
    if (bus.rows !== 8'h20) begin
      mismatched++; $display("FAIL rst_row5_lit got %h want 20", bus.rows);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (bus.rows !== 8'h00) begin
      mismatched++; $display("FAIL rst_mid_rows got %h want 00", bus.rows);
    end
    compared++;
    if (bus.cols !== 8'hFF) begin
      mismatched++; $display("FAIL rst_mid_cols got %h want FF", bus.cols);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    disp_exp = '0;
    for (int i = 0; i < 24; i++) begin
      tick_cycle();
      compared++;
      if (bus.rows !== exp_rows(t)) begin
        mismatched++; $display("FAIL rst_scan_rows t=%0d got %h want %h", t, bus.rows, exp_rows(t));
      end
      compared++;
      if (bus.cols !== 8'hFF) begin
        mismatched++; $display("FAIL rst_scan_cols t=%0d got %h want FF", t, bus.cols);
      end
    end
  endtask

  task automatic test_ena_slow();
    int n;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    disp_exp = '0;
    n = 0;
    // load lands on a cycle without ena: capture must still happen
    while (t < 25) begin
      bus.ena   = (n % 4 == 0);
      bus.load  = (n == 1);
      bus.cells = (n == 1) ? 64'h0000_0000_0000_00A5 : 64'h0;
      tick_cycle();
      n++;
      bus.load  = 1'b0;
      bus.cells = 64'h0;
      if (ticked && t == 24) disp_exp = 64'h0000_0000_0000_00A5;
      compared++;
      if (bus.rows !== exp_rows(t)) begin
        mismatched++; $display("FAIL slow_rows n=%0d got %h want %h", n, bus.rows, exp_rows(t));
      end
      compared++;
      if (bus.cols !== exp_cols(t, disp_exp)) begin
        mismatched++; $display("FAIL slow_cols n=%0d got %h want %h", n, bus.cols, exp_cols(t, disp_exp));
      end
      compared++;
      if (bus.frame_done !== (ticked && (t % 24 == 0))) begin
        mismatched++; $display("FAIL slow_frame_done n=%0d got %b want %b", n, bus.frame_done, (ticked && (t % 24 == 0)));
      end
    end
    bus.ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      compared++;
      if (bus.rows !== 8'h01) begin
        mismatched++; $display("FAIL freeze_rows i=%0d got %h want 01", i, bus.rows);
      end
      compared++;
      if (bus.cols !== 8'h5A) begin
        mismatched++; $display("FAIL freeze_cols i=%0d got %h want 5A", i, bus.cols);
      end
    end
    bus.ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_two_loads();
    test_load_on_boundary();
    test_reset_mid_row();
    test_ena_slow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
